xaui_link_manager: RTL and testbench

//  Per-port XAUI link bring-up and health controller, one instance alongside the MGT infrastructure.

---
 rtl/xaui_link_manager_if.sv | 34 +++
 rtl/xaui_link_manager.sv | 168 ++++++++++++++++
 tb/tb_xaui_link_manager.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/xaui_link_manager_if.sv
// Bundles the per-lane MGT status/control vectors and the per-port link
// status of the XAUI link manager. Vectors are packed port-major.
interface xaui_link_manager_if #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned LANES   = 4
);
    logic [N_PORTS*LANES-1:0]   mgt_rxlock;
    logic [N_PORTS*LANES-1:0]   mgt_syncok;
    logic [N_PORTS*LANES*2-1:0] mgt_codevalid;
    logic [N_PORTS*LANES-1:0]   mgt_rxbufferr;
    logic [N_PORTS-1:0]         force_retrain;

    logic [N_PORTS*LANES-1:0]   mgt_tx_reset;
    logic [N_PORTS*LANES-1:0]   mgt_rx_reset;
    logic [N_PORTS*LANES-1:0]   mgt_enable_align;
    logic [N_PORTS-1:0]         mgt_enchansync;
    logic [N_PORTS-1:0]         link_up;
    logic [N_PORTS*3-1:0]       link_state;
    logic [N_PORTS*8-1:0]       retrain_cnt;

    // Transceiver/software side: drives status, observes control.
    modport master (
        output mgt_rxlock, mgt_syncok, mgt_codevalid, mgt_rxbufferr, force_retrain,
        input  mgt_tx_reset, mgt_rx_reset, mgt_enable_align, mgt_enchansync,
        input  link_up, link_state, retrain_cnt
    );

    // Link manager side.
    modport slave (
        input  mgt_rxlock, mgt_syncok, mgt_codevalid, mgt_rxbufferr, force_retrain,
        output mgt_tx_reset, mgt_rx_reset, mgt_enable_align, mgt_enchansync,
        output link_up, link_state, retrain_cnt
    );
endinterface

// File: rtl/xaui_link_manager.sv
// XAUI link bring-up and health controller. One independent Moore FSM per
// port sequences MGT reset, CDR lock, comma alignment and channel bonding,
// then watches the link and retrains after a back-off on lock loss, an error
// burst or a software request.
module xaui_link_manager #(
    parameter int unsigned         N_PORTS        = 4,
    parameter int unsigned         LANES          = 4,
    parameter logic [N_PORTS-1:0]  DISABLE_MASK   = 4'b1110,
    parameter int unsigned         RESET_CYCLES   = 64,
    parameter int unsigned         LOCK_TIMEOUT   = 65536,
    parameter int unsigned         SYNC_TIMEOUT   = 65536,
    parameter int unsigned         STABLE_CYCLES  = 16,
    parameter int unsigned         ERR_WINDOW     = 1024,
    parameter int unsigned         ERR_THRESH     = 8,
    parameter int unsigned         BACKOFF_CYCLES = 4096
) (
    input logic           mgt_clk,
    input logic           mgt_reset_n,
    xaui_link_manager_if.slave bus
);
    // One counter width covers every timeout, window and threshold.
    localparam int unsigned MaxA = (LOCK_TIMEOUT > SYNC_TIMEOUT) ? LOCK_TIMEOUT : SYNC_TIMEOUT;
    localparam int unsigned MaxB = (RESET_CYCLES > BACKOFF_CYCLES) ? RESET_CYCLES : BACKOFF_CYCLES;
    localparam int unsigned MaxC = (ERR_WINDOW > STABLE_CYCLES) ? ERR_WINDOW : STABLE_CYCLES;
    localparam int unsigned MaxD = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned MaxT = (MaxC > MaxD) ? MaxC : MaxD;
    localparam int unsigned TW   = $clog2(MaxT) + 1;

    localparam logic [TW-1:0] ResetLast   = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] LockLast    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SyncLast    = TW'(SYNC_TIMEOUT - 1);
    localparam logic [TW-1:0] BackoffLast = TW'(BACKOFF_CYCLES - 1);
    localparam logic [TW-1:0] WinLast     = TW'(ERR_WINDOW - 1);
    localparam logic [TW-1:0] StableN     = TW'(STABLE_CYCLES);
    localparam logic [TW-1:0] ErrThresh   = TW'(ERR_THRESH);

    typedef enum logic [2:0] {
        StDisabled = 3'd0,
        StReset    = 3'd1,
        StWaitLock = 3'd2,
        StAlign    = 3'd3,
        StChansync = 3'd4,
        StUp       = 3'd5,
        StBackoff  = 3'd6
    } state_e;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        if (DISABLE_MASK[p]) begin : g_off
            // Masked port: constant outputs, inputs deliberately unused.
            logic unused_inputs;
            assign unused_inputs = ^{bus.mgt_rxlock[p*LANES +: LANES],
                                     bus.mgt_syncok[p*LANES +: LANES],
                                     bus.mgt_codevalid[p*LANES*2 +: LANES*2],
                                     bus.mgt_rxbufferr[p*LANES +: LANES],
                                     bus.force_retrain[p]};

            assign bus.mgt_tx_reset[p*LANES +: LANES]     = '1;
            assign bus.mgt_rx_reset[p*LANES +: LANES]     = '1;
            assign bus.mgt_enable_align[p*LANES +: LANES] = '0;
            assign bus.mgt_enchansync[p]                  = 1'b0;
            assign bus.link_up[p]                         = 1'b0;
            assign bus.link_state[p*3 +: 3]               = StDisabled;
            assign bus.retrain_cnt[p*8 +: 8]              = '0;
        end else begin : g_on
            state_e        state_q, state_d;
            logic [TW-1:0] timer_q, timer_d;
            logic [TW-1:0] stable_q, stable_d;
            logic [TW-1:0] win_q, win_d;
            logic [TW-1:0] err_q, err_d;
            logic [7:0]    cnt_q, cnt_d;
            logic          lock, sync, valid, err_event, retrain;

            assign lock      = &bus.mgt_rxlock[p*LANES +: LANES];
            assign sync      = &bus.mgt_syncok[p*LANES +: LANES];
            assign valid     = &bus.mgt_codevalid[p*LANES*2 +: LANES*2];
            assign err_event = (|bus.mgt_rxbufferr[p*LANES +: LANES]) | ~valid;
            assign retrain   = bus.force_retrain[p];

            // Next-state logic; all auxiliary counters restart on any state change.
            always_comb begin
                state_d  = state_q;
                timer_d  = timer_q + 1'b1;
                stable_d = stable_q;
                win_d    = win_q;
                err_d    = err_q;
                cnt_d    = cnt_q;
                unique case (state_q)
                    StReset: begin
                        if (timer_q == ResetLast) state_d = StWaitLock;
                    end
                    StWaitLock: begin
                        if (retrain)                   state_d = StBackoff;
                        else if (lock)                 state_d = StAlign;
                        else if (timer_q == LockLast)  state_d = StBackoff;
                    end
                    StAlign: begin
                        if (retrain)                   state_d = StBackoff;
                        else if (sync)                 state_d = StChansync;
                        else if (timer_q == SyncLast)  state_d = StBackoff;
                    end
                    StChansync: begin
                        if (retrain)                   state_d = StBackoff;
                        else if (stable_q == StableN)  state_d = StUp;
                        else if (timer_q == SyncLast)  state_d = StBackoff;
                        else stable_d = valid ? stable_q + 1'b1 : '0;
                    end
                    StUp: begin
                        // Threshold is checked before the window clear so a
                        // last-cycle error still counts in the expiring window.
                        if (retrain || !lock || ((err_q + TW'(err_event)) >= ErrThresh)) begin
                            state_d = StBackoff;
                        end else if (win_q == WinLast) begin
                            win_d = '0;
                            err_d = '0;
                        end else begin
                            win_d = win_q + 1'b1;
                            err_d = err_q + TW'(err_event);
                        end
                    end
                    StBackoff: begin
                        if (timer_q == BackoffLast) state_d = StReset;
                    end
                    default: state_d = StReset;
                endcase
                if (state_d != state_q) begin
                    timer_d  = '0;
                    stable_d = '0;
                    win_d    = '0;
                    err_d    = '0;
                    if (state_d == StBackoff && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end

            // State and counter registers with synchronous active-low reset.
            always_ff @(posedge mgt_clk) begin
                if (!mgt_reset_n) begin
                    state_q  <= StReset;
                    timer_q  <= '0;
                    stable_q <= '0;
                    win_q    <= '0;
                    err_q    <= '0;
                    cnt_q    <= '0;
                end else begin
                    state_q  <= state_d;
                    timer_q  <= timer_d;
                    stable_q <= stable_d;
                    win_q    <= win_d;
                    err_q    <= err_d;
                    cnt_q    <= cnt_d;
                end
            end

            // Moore outputs decoded straight from the state register.
            logic in_reset, aligning, bonding;
            assign in_reset = (state_q == StReset) || (state_q == StBackoff);
            assign aligning = (state_q == StAlign) || (state_q == StChansync) || (state_q == StUp);
            assign bonding  = (state_q == StChansync) || (state_q == StUp);

            assign bus.mgt_tx_reset[p*LANES +: LANES]     = {LANES{in_reset}};
            assign bus.mgt_rx_reset[p*LANES +: LANES]     = {LANES{in_reset}};
            assign bus.mgt_enable_align[p*LANES +: LANES] = {LANES{aligning}};
            assign bus.mgt_enchansync[p]                  = bonding;
            assign bus.link_up[p]                         = (state_q == StUp);
            assign bus.link_state[p*3 +: 3]               = state_q;
            assign bus.retrain_cnt[p*8 +: 8]              = cnt_q;
        end
    end
endmodule

// File: tb/tb_xaui_link_manager.sv
// Bench for xaui_link_manager: a per-port behavioural model checked against
// every output each cycle, plus hand-computed milestones on ports 0 and 2.
module tb_xaui_link_manager;
    localparam int NP = 4;
    localparam int NL = 4;
    localparam int RC = 4;
    localparam int LT = 32;
    localparam int ST = 32;
    localparam int SC = 4;
    localparam int EW = 16;
    localparam int ET = 3;
    localparam int BC = 8;
    localparam logic [NP-1:0] MASK = 4'b1010;

    logic mgt_clk = 1'b0;
    logic mgt_reset_n = 1'b0;

    xaui_link_manager_if #(.N_PORTS(NP), .LANES(NL)) bus ();

    xaui_link_manager #(
        .N_PORTS(NP), .LANES(NL), .DISABLE_MASK(MASK), .RESET_CYCLES(RC),
        .LOCK_TIMEOUT(LT), .SYNC_TIMEOUT(ST), .STABLE_CYCLES(SC),
        .ERR_WINDOW(EW), .ERR_THRESH(ET), .BACKOFF_CYCLES(BC)
    ) dut (
        .mgt_clk(mgt_clk),
        .mgt_reset_n(mgt_reset_n),
        .bus(bus)
    );

    always #5 mgt_clk = ~mgt_clk;

    int checks = 0;
    int fails = 0;

    task automatic check(input string name, input int port, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s port %0d: got %0d, expected %0d (t=%0t)", name, port, act, exp, $time);
        end
    endtask

    // Behavioural model: state per port plus cycles spent in it.
    int m_state[NP];
    int m_age[NP];
    int m_run[NP];
    int m_err[NP];
    int m_cnt[NP];
    bit m_live = 1'b0;

    task automatic model_step(input int p);
        bit lock, sync, clean, err, fr;
        int nxt;
        lock  = &bus.mgt_rxlock[p*NL +: NL];
        sync  = &bus.mgt_syncok[p*NL +: NL];
        clean = &bus.mgt_codevalid[p*NL*2 +: NL*2];
        err   = (|bus.mgt_rxbufferr[p*NL +: NL]) || !clean;
        fr    = bus.force_retrain[p];
        if (MASK[p]) begin
            m_state[p] = 0;
            m_cnt[p] = 0;
            return;
        end
        if (!mgt_reset_n) begin
            m_state[p] = 1; m_age[p] = 0; m_run[p] = 0; m_err[p] = 0; m_cnt[p] = 0;
            return;
        end
        nxt = m_state[p];
        case (m_state[p])
            1: if (m_age[p] + 1 == RC) nxt = 2;
            2: if (fr) nxt = 6; else if (lock) nxt = 3; else if (m_age[p] + 1 == LT) nxt = 6;
            3: if (fr) nxt = 6; else if (sync) nxt = 4; else if (m_age[p] + 1 == ST) nxt = 6;
            4: begin
                if (fr) nxt = 6;
                else if (m_run[p] == SC) nxt = 5;
                else if (m_age[p] + 1 == ST) nxt = 6;
                else m_run[p] = clean ? m_run[p] + 1 : 0;
            end
            5: begin
                if (fr || !lock || (m_err[p] + int'(err) >= ET)) nxt = 6;
                else if (m_age[p] % EW == EW - 1) m_err[p] = 0;
                else m_err[p] += int'(err);
            end
            6: if (m_age[p] + 1 == BC) nxt = 1;
            default: nxt = 1;
        endcase
        if (nxt != m_state[p]) begin
            if (nxt == 6 && m_cnt[p] < 255) m_cnt[p]++;
            m_state[p] = nxt; m_age[p] = 0; m_run[p] = 0; m_err[p] = 0;
        end else begin
            m_age[p]++;
        end
    endtask

    always @(posedge mgt_clk) begin
        for (int p = 0; p < NP; p++) model_step(p);
        if (!mgt_reset_n) m_live = 1'b1;
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge mgt_clk) begin
        if (m_live) begin
            for (int p = 0; p < NP; p++) begin
                int st;
                st = m_state[p];
                check("link_state", p, bus.link_state[p*3 +: 3], st);
                check("tx_reset", p, bus.mgt_tx_reset[p*NL +: NL], (st inside {0, 1, 6}) ? 15 : 0);
                check("rx_reset", p, bus.mgt_rx_reset[p*NL +: NL], (st inside {0, 1, 6}) ? 15 : 0);
                check("enable_align", p, bus.mgt_enable_align[p*NL +: NL], (st inside {3, 4, 5}) ? 15 : 0);
                check("enchansync", p, bus.mgt_enchansync[p], (st inside {4, 5}) ? 1 : 0);
                check("link_up", p, bus.link_up[p], (st == 5) ? 1 : 0);
                check("retrain_cnt", p, bus.retrain_cnt[p*8 +: 8], m_cnt[p]);
            end
        end
    end

    task automatic wait_state(input int p, input int st, input int bound, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge mgt_clk);
            if (bus.link_state[p*3 +: 3] == 3'(st)) seen = 1'b1;
        end
        check(name, p, seen, 1);
    endtask

    initial begin
        bus.mgt_rxlock    = '1;
        bus.mgt_syncok    = '1;
        bus.mgt_codevalid = '1;
        bus.mgt_rxbufferr = '0;
        bus.force_retrain = '0;
        bus.mgt_rxlock[2*NL +: NL] = '0;  // port 2 never locks
        mgt_reset_n = 1'b0;
        repeat (2) @(negedge mgt_clk);
        mgt_reset_n = 1'b1;

        // Clean bring-up on port 0, lock-timeout loops on port 2.
        for (int n = 1; n <= 130; n++) begin
            @(negedge mgt_clk);
            if (n == 1) begin
                check("t1 reset state", 0, bus.link_state[2:0], 1);
                check("t1 reset tx", 0, bus.mgt_tx_reset[3:0], 15);
                check("t1 reset cnt", 0, bus.retrain_cnt[7:0], 0);
                check("t1 masked state", 1, bus.link_state[5:3], 0);
                check("t1 masked rx", 3, bus.mgt_rx_reset[15:12], 15);
            end
            if (n == 3)  check("t1 still reset", 0, bus.link_state[2:0], 1);
            if (n == 4)  check("t1 wait_lock", 0, bus.link_state[2:0], 2);
            if (n == 5)  check("t1 align", 0, bus.link_state[2:0], 3);
            if (n == 6)  check("t1 chansync", 0, bus.link_state[2:0], 4);
            if (n == 10) check("t1 not yet up", 0, bus.link_up[0], 0);
            if (n == 11) check("t1 up at 11", 0, bus.link_up[0], 1);
            if (n == 35) check("t2 wait_lock end", 2, bus.link_state[8:6], 2);
            if (n == 36) check("t2 backoff 1", 2, bus.retrain_cnt[23:16], 1);
            if (n == 80) check("t2 backoff 2", 2, bus.retrain_cnt[23:16], 2);
            if (n == 130) begin
                check("t2 backoff 3 cnt", 2, bus.retrain_cnt[23:16], 3);
                check("t2 backoff 3 state", 2, bus.link_state[8:6], 6);
            end
        end

        // Three consecutive code errors in UP.
        bus.mgt_codevalid[0] = 1'b0;
        @(negedge mgt_clk);
        check("t3 err1 up", 0, bus.link_state[2:0], 5);
        @(negedge mgt_clk);
        check("t3 err2 up", 0, bus.link_state[2:0], 5);
        @(negedge mgt_clk);
        bus.mgt_codevalid[0] = 1'b1;
        check("t3 err3 backoff", 0, bus.link_state[2:0], 6);
        check("t3 cnt", 0, bus.retrain_cnt[7:0], 1);

        // Glitch in CHANSYNC at stable count 3.
        wait_state(0, 4, 60, "t4 reach chansync");
        repeat (3) @(negedge mgt_clk);
        bus.mgt_codevalid[5] = 1'b0;
        @(negedge mgt_clk);
        bus.mgt_codevalid[5] = 1'b1;
        repeat (4) @(negedge mgt_clk);
        check("t4 still chansync", 0, bus.link_state[2:0], 4);
        @(negedge mgt_clk);
        check("t4 up after restart", 0, bus.link_up[0], 1);

        // Two buffer errors at the end of each window, ten windows.
        for (int i = 0; i < 10 * EW; i++) begin
            bus.mgt_rxbufferr[1] = ((i % EW) >= EW - 2);
            @(negedge mgt_clk);
        end
        bus.mgt_rxbufferr[1] = 1'b0;
        check("t3b stays up", 0, bus.link_state[2:0], 5);
        check("t3b cnt", 0, bus.retrain_cnt[7:0], 1);

        // force_retrain together with a lock drop.
        bus.force_retrain[0] = 1'b1;
        bus.mgt_rxlock[2] = 1'b0;
        @(negedge mgt_clk);
        bus.force_retrain[0] = 1'b0;
        bus.mgt_rxlock[2] = 1'b1;
        check("t5 backoff", 0, bus.link_state[2:0], 6);
        check("t5 single inc", 0, bus.retrain_cnt[7:0], 2);
        @(negedge mgt_clk);
        check("t5 no double inc", 0, bus.retrain_cnt[7:0], 2);

        // Reset pulse while UP, then saturate the retrain counter.
        wait_state(0, 5, 60, "t6 reach up");
        mgt_reset_n = 1'b0;
        @(negedge mgt_clk);
        mgt_reset_n = 1'b1;
        check("t6 reset state", 0, bus.link_state[2:0], 1);
        check("t6 reset cnt", 0, bus.retrain_cnt[7:0], 0);
        check("t6 reset link_up", 0, bus.link_up[0], 0);
        check("t6 reset tx", 0, bus.mgt_tx_reset[3:0], 15);
        bus.force_retrain[0] = 1'b1;
        for (int k = 1; k <= 3920; k++) begin
            @(negedge mgt_clk);
            if (k == 4)    check("t6 wait_lock", 0, bus.link_state[2:0], 2);
            if (k == 5)    check("t6 first retrain", 0, bus.retrain_cnt[7:0], 1);
            if (k == 18)   check("t6 second retrain", 0, bus.retrain_cnt[7:0], 2);
            if (k == 3306) check("t6 cnt 254", 0, bus.retrain_cnt[7:0], 254);
            if (k == 3307) check("t6 cnt 255", 0, bus.retrain_cnt[7:0], 255);
            if (k == 3920) check("t6 saturated", 0, bus.retrain_cnt[7:0], 255);
        end
        bus.force_retrain[0] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
